// File: rtl/conv_ext_arbiter.sv
// Round-robin arbitrated sign/zero-extension engine: NREQ narrow-field requesters
// share one extender feeding a two-stage valid/ready pipeline (S1 capture, S2 output).
module conv_ext_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 8,
  parameter int OW   = 32,
  parameter int WB   = $clog2(IW)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*IW-1:0]       req_data,
  input  logic [NREQ*WB-1:0]       req_wm1,
  input  logic [NREQ-1:0]          req_signed,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OW-1:0]            res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [15:0]              conv_cnt
);

  localparam int IDW = $clog2(NREQ);

  // Keep only bits [wm1:0] of the field.
  function automatic logic [IW-1:0] mask_f(input logic [IW-1:0] d, input logic [WB-1:0] wm1);
    logic [IW-1:0] m;
    m = '0;
    for (int b = 0; b < IW; b++) m[b] = (b <= int'(wm1)) ? d[b] : 1'b0;
    return m;
  endfunction

  // Fill bits above wm1 with bit wm1 (signed) or zero (unsigned).
  function automatic logic [OW-1:0] ext_f(input logic [IW-1:0] d, input logic [WB-1:0] wm1,
                                          input logic sgn);
    logic          sb;
    logic [OW-1:0] r;
    sb = 1'b0;
    for (int b = 0; b < IW; b++) sb = (b == int'(wm1)) ? d[b] : sb;
    r = {OW{sgn & sb}};
    for (int b = 0; b < IW; b++) r[b] = (b <= int'(wm1)) ? d[b] : r[b];
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [IW-1:0]    s1_data_q, s1_data_d;
  logic [WB-1:0]    s1_wm1_q, s1_wm1_d;
  logic             s1_signed_q, s1_signed_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             res_valid_q, res_valid_d;
  logic [OW-1:0]    res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [15:0]      conv_cnt_q, conv_cnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             hi_hit_s, hi_found_s, lo_found_s;
  logic [IDW-1:0]   hi_idx_s, lo_idx_s;
  logic             gnt_found_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [IW-1:0]    sel_data_s;
  logic [WB-1:0]    sel_wm1_raw_s, sel_wm1_s;
  logic             sel_signed_s;
  logic             s2_free_s, s1_free_s, accept_s;

  // Round-robin search: lowest valid index at/above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_hit_s   = 1'b0;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      hi_hit_s   = req_valid[i] && (IDW'(i) >= rr_ptr_q);
      hi_found_s = hi_found_s | hi_hit_s;
      hi_idx_s   = hi_hit_s ? IDW'(i) : hi_idx_s;
      lo_found_s = lo_found_s | req_valid[i];
      lo_idx_s   = req_valid[i] ? IDW'(i) : lo_idx_s;
    end
    gnt_found_s = lo_found_s;
    gnt_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Mux the granted requester's fields and clamp its width code.
  always_comb begin
    sel_data_s    = '0;
    sel_wm1_raw_s = '0;
    sel_signed_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data_s    = (IDW'(i) == gnt_idx_s) ? req_data[i*IW +: IW] : sel_data_s;
      sel_wm1_raw_s = (IDW'(i) == gnt_idx_s) ? req_wm1[i*WB +: WB] : sel_wm1_raw_s;
      sel_signed_s  = (IDW'(i) == gnt_idx_s) ? req_signed[i] : sel_signed_s;
    end
    sel_wm1_s = (int'(sel_wm1_raw_s) >= IW - 1) ? WB'(IW - 1) : sel_wm1_raw_s;
  end

  // Handshake qualifiers and the one-hot ready vector.
  always_comb begin
    s2_free_s = !res_valid_q || res_ready;
    s1_free_s = !s1_valid_q || s2_free_s;
    accept_s  = gnt_found_s && s1_free_s;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) req_ready[i] = accept_s && (gnt_idx_s == IDW'(i));
  end

  // Next-state for both pipeline stages, the pointer and the handoff counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_wm1_d    = s1_wm1_q;
    s1_signed_d = s1_signed_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (accept_s) begin
      s1_valid_d  = 1'b1;
      s1_data_d   = mask_f(sel_data_s, sel_wm1_s);
      s1_wm1_d    = sel_wm1_s;
      s1_signed_d = sel_signed_s;
      s1_id_d     = gnt_idx_s;
      rr_ptr_d    = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
    end else if (s2_free_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    // Payload only moves with a valid S1 so an idle S2 keeps its last result.
    if (s2_free_s) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_data_d = ext_f(s1_data_q, s1_wm1_q, s1_signed_q);
        res_id_d   = s1_id_q;
      end else begin
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
      end
    end else begin
      res_valid_d = res_valid_q;
    end
    conv_cnt_d = (res_valid_q && res_ready) ? conv_cnt_q + 16'd1 : conv_cnt_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_wm1_q    <= '0;
      s1_signed_q <= 1'b0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      conv_cnt_q  <= 16'd0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_wm1_q    <= s1_wm1_d;
      s1_signed_q <= s1_signed_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      conv_cnt_q  <= conv_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign conv_cnt  = conv_cnt_q;

endmodule
